fifo_flags: RTL and testbench
=============================

Name: fifo_flags

Overview:
Parametrised synchronous single-clock FIFO. It is the successor to the team's basic power-of-two FIFO.
- Supports any DEPTH ≥ 2, not only powers of two.
- Adds an occupancy count, programmable almost-full and almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags.
- Sits between producer and consumer stages wherever back-pressure needs early warning.

Parameters:
- DEPTH, 4: number of entries; any integer ≥ 2.
- WIDTH, 32: data width in bits.
- AF_LEVEL, DEPTH-1: almost_full asserts when level ≥ AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 1: almost_empty asserts when level ≤ AE_LEVEL; legal range 0..DEPTH-1.
- CW (localparam), $clog2(DEPTH+1): width of level.
- PW (localparam), max(1,$clog2(DEPTH)): pointer width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset. Assertion clears state immediately; deassertion is synchronous to clk externally.
- clear  in  1  synchronous flush. Empties the FIFO on the next edge and has priority over wr/rd.
- wr  in  1  write request.
- wr_data  in  WIDTH  write data, sampled on an accepted write.
- rd  in  1  read request; pops the head entry on an accepted read.
- rd_data  out  WIDTH  head entry, show-ahead and combinational from memory. Content is don't-care while empty.
- level  out  CW  number of valid entries, 0..DEPTH.
- empty  out  1  level==0.
- full  out  1  level==DEPTH.
- almost_empty  out  1  level ≤ AE_LEVEL.
- almost_full  out  1  level ≥ AF_LEVEL.
- overflow  out  1  sticky; set by a rejected write.
- underflow  out  1  sticky; set by a rejected read.

Behaviour:
- State: wrptr and rdptr (PW bits each), level register (CW bits), overflow and underflow registers, memory array of DEPTH×WIDTH. The memory is not reset.
- Reset (rst=0, asynchronous):
  - wrptr=0, rdptr=0, level=0, overflow=0, underflow=0.
  - Outputs therefore read empty=1, full=0, almost_empty=1, almost_full=0.
- Flags are combinational decodes of the registered level, so they are valid in the same cycle as the edge that changed level. There are no extra cycles of latency.
- Accept rules, evaluated on the current-cycle state:
  - rd_ok = rd & ~empty.
  - wr_ok = wr & (~full | rd_ok). Writing into a full FIFO is allowed when a read pops in the same cycle.
  - A read on an empty FIFO is never satisfied by the same-cycle write (no bypass). In that case the write is accepted and the read is rejected.
- Pointer wrap: a pointer equal to DEPTH-1 wraps to 0 on increment. There is no reliance on binary overflow, so non-power-of-two depths are exact.
- Write: on wr_ok, mem[wrptr] ← wr_data and wrptr advances.
- Read: on rd_ok, rdptr advances. rd_data shows the new head after the edge.
- Level update:
  - +1 if wr_ok & ~rd_ok.
  - −1 if rd_ok & ~wr_ok.
  - Unchanged otherwise, including a simultaneous accepted read and write.
- Errors:
  - overflow ← 1 if wr & ~wr_ok.
  - underflow ← 1 if rd & ~rd_ok.
  - Both are sticky until reset or clear.
  - A rejected access changes no pointer, level or memory location.
- clear=1 at an edge:
  - wrptr, rdptr, level, overflow and underflow all go to 0.
  - wr and rd in that cycle are ignored and raise no error flags.
  - Memory contents are left as they were.
- Reset mid-operation: all queued entries are discarded. After rst deasserts, the first read returns only data written after reset.
- Invalid parameter values (AF_LEVEL or AE_LEVEL out of range, DEPTH<2) must be caught by an elaboration-time check that stops the build.

Test Plan:
All scenarios use DEPTH=5, WIDTH=8, AF_LEVEL=4, AE_LEVEL=1 unless stated.
1. Fill then drain:
   - Write 0x11..0x55 on 5 consecutive cycles → level steps 1..5. almost_empty drops when level reaches 2; almost_full rises at 4; full rises at 5.
   - Then read 5 cycles → rd_data is 0x11,0x22,0x33,0x44,0x55 in order, and empty=1 at the end.
2. Wrap-around at non-power-of-two depth:
   - Perform 13 single write/read pairs, with the FIFO holding 2 entries throughout.
   - Required: data order is preserved across pointer wrap 4→0, level stays 2, and no flag errors occur.
3. Overflow:
   - Fill to 5, then wr=1 with data 0x99 and rd=0 → overflow=1 from the next cycle, level=5.
   - Draining returns 0x11..0x55, and 0x99 never appears.
   - Then, with the FIFO full, assert wr and rd together → level stays 5, overflow stays 1, and the new data appears last.
4. Underflow with simultaneous write:
   - Empty FIFO, rd=1, wr=1 with data 0xA5 → underflow=1, level=1, rd_data=0xA5 after the edge.
5. Clear:
   - Write 3 entries with overflow already set, then clear=1 with wr=1 → level=0, empty=1, overflow=0. The write is dropped.
6. Asynchronous reset:
   - Drive rst low mid-cycle while level=3 → level=0, empty=1 and the flags clear before the next clk edge.
   - After release, a write of 0x7E followed by a read returns 0x7E.

Source files
------------

// File: rtl/fifo_flags.sv
// Single-clock FIFO for any depth >= 2 with occupancy count, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module fifo_flags #(
    parameter int DEPTH    = 4,
    parameter int WIDTH    = 32,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         wr,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_empty,
    output logic                         almost_full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    // Refuse to build with thresholds or depth outside their legal ranges.
    generate
        if (DEPTH < 2 || AF_LEVEL < 1 || AF_LEVEL > DEPTH ||
            AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_param_err
            $fatal(1, "fifo_flags: illegal DEPTH/AF_LEVEL/AE_LEVEL");
        end
    endgenerate

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wrptr;
    logic [PW-1:0]    r_rdptr;
    logic [CW-1:0]    r_level;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic             w_rd_ok;
    logic             w_wr_ok;

    // Explicit wrap at DEPTH-1 keeps non-power-of-two depths exact.
    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == CW'(DEPTH));
    assign w_rd_ok = rd & ~w_empty;
    assign w_wr_ok = wr & (~w_full | w_rd_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrptr     <= '0;
            r_rdptr     <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clear) begin
            r_wrptr     <= '0;
            r_rdptr     <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wrptr <= f_inc(r_wrptr);
            end
            if (w_rd_ok) begin
                r_rdptr <= f_inc(r_rdptr);
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_level <= r_level + CW'(1);
                2'b01:   r_level <= r_level - CW'(1);
                default: r_level <= r_level;
            endcase
            if (wr & ~w_wr_ok) begin
                r_overflow <= 1'b1;
            end
            if (rd & ~w_rd_ok) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Storage is intentionally not reset; flush only moves pointers.
    always_ff @(posedge clk) begin
        if (w_wr_ok && !clear) begin
            r_mem[r_wrptr] <= wr_data;
        end
    end

    assign rd_data      = r_mem[r_rdptr];
    assign level        = r_level;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (r_level <= CW'(AE_LEVEL));
    assign almost_full  = (r_level >= CW'(AF_LEVEL));
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_flags.sv
// Scoreboard bench for fifo_flags (DEPTH=5, WIDTH=8, AF=4, AE=1): stimulus queues
// expected head data and post-edge status; a monitor pops and compares.
module tb_fifo_flags;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       wr;
    logic [7:0] wr_data;
    logic       rd;
    logic [7:0] rd_data;
    logic [2:0] level;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic       overflow;
    logic       underflow;

    fifo_flags #(.DEPTH(5), .WIDTH(8), .AF_LEVEL(4), .AE_LEVEL(1)) dut (
        .clk          (clk),
        .rst          (rst_n),
        .clear        (clear),
        .wr           (wr),
        .wr_data      (wr_data),
        .rd           (rd),
        .rd_data      (rd_data),
        .level        (level),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    typedef struct {
        int         stamp;
        logic [7:0] d;
    } rd_exp_t;

    typedef struct {
        int         stamp;
        logic [8:0] s;
    } st_exp_t;

    rd_exp_t rq[$];
    st_exp_t sq[$];
    rd_exp_t re;
    st_exp_t se;
    int      cyc   = 0;
    int      total = 0;
    int      bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:0] mk(input int lvl, input logic ov, input logic un);
        return {3'(lvl), (lvl == 0), (lvl == 5), (lvl <= 1), (lvl >= 4), ov, un};
    endfunction

    function automatic void chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endfunction

    function automatic logic [8:0] status();
        return {level, empty, full, almost_empty, almost_full, overflow, underflow};
    endfunction

    // One cycle of stimulus; expectations are queued with the cycle they apply to.
    task automatic step(input logic w, input logic [7:0] wd, input logic r, input logic c,
                        input logic chk_r, input logic [7:0] exp_rd,
                        input int lvl, input logic ov, input logic un);
        @(negedge clk);
        wr      = w;
        wr_data = wd;
        rd      = r;
        clear   = c;
        if (chk_r) rq.push_back('{cyc, exp_rd});
        sq.push_back('{cyc + 1, mk(lvl, ov, un)});
    endtask

    // Monitor: mid-low-phase, compare head data and status due this cycle.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            while (rq.size() > 0 && rq[0].stamp <= cyc) begin
                re = rq.pop_front();
                chk("rd_data", {1'b0, rd_data}, {1'b0, re.d});
            end
            while (sq.size() > 0 && sq[0].stamp <= cyc) begin
                se = sq.pop_front();
                chk("status", status(), se.s);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b1;
        clear   = 1'b0;
        wr      = 1'b0;
        wr_data = 8'h00;
        rd      = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk("reset_status", status(), mk(0, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        // Fill then drain
        for (int i = 0; i < 5; i++) step(1, 8'(17 * (i + 1)), 0, 0, 0, 8'h00, i + 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 1, 8'(17 * (i + 1)), 4 - i, 0, 0);

        // Wrap-around with two entries resident
        step(1, 8'h01, 0, 0, 0, 8'h00, 1, 0, 0);
        step(1, 8'h02, 0, 0, 0, 8'h00, 2, 0, 0);
        for (int i = 0; i < 13; i++) step(1, 8'(3 + i), 1, 0, 1, 8'(1 + i), 2, 0, 0);
        step(0, 8'h00, 1, 0, 1, 8'h0E, 1, 0, 0);
        step(0, 8'h00, 1, 0, 1, 8'h0F, 0, 0, 0);

        // Overflow, then full write+read
        for (int i = 0; i < 5; i++) step(1, 8'(17 * (i + 1)), 0, 0, 0, 8'h00, i + 1, 0, 0);
        step(1, 8'h99, 0, 0, 0, 8'h00, 5, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 1, 8'(17 * (i + 1)), 4 - i, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 8'(8'h61 + i), 0, 0, 0, 8'h00, i + 1, 1, 0);
        step(1, 8'h99, 1, 0, 1, 8'h61, 5, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 1, 8'(8'h62 + i), 4 - i, 1, 0);
        step(0, 8'h00, 1, 0, 1, 8'h99, 0, 1, 0);

        // Underflow with simultaneous write (no bypass)
        step(1, 8'hA5, 1, 0, 0, 8'h00, 1, 1, 1);
        step(0, 8'h00, 1, 0, 1, 8'hA5, 0, 1, 1);

        // Clear beats a same-cycle write and drops error flags
        for (int i = 0; i < 3; i++) step(1, 8'(8'h31 + i), 0, 0, 0, 8'h00, i + 1, 1, 1);
        step(1, 8'h44, 0, 1, 0, 8'h00, 0, 0, 0);
        step(1, 8'h56, 0, 0, 0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 1, 8'h56, 0, 0, 0);

        // Asynchronous reset mid-cycle with three entries queued
        for (int i = 0; i < 3; i++) step(1, 8'(8'h71 + i), 0, 0, 0, 8'h00, i + 1, 0, 0);
        @(negedge clk);
        wr = 1'b0;
        rd = 1'b0;
        #3 rst_n = 1'b0;
        #1 chk("async_reset", status(), mk(0, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 8'h7E, 0, 0, 0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 1, 8'h7E, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);

        @(negedge clk);
        #4;
        chk("rd_queue_drained", 9'(rq.size()), 9'd0);
        chk("st_queue_drained", 9'(sq.size()), 9'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
